// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types and constants, plus the reference round-robin pick used
// to cross-check the arbiter's priority encoder.
package cbus_arbiter_pkg;

    localparam int CBUS_AW     = 32;
    localparam int CBUS_DW     = 32;
    localparam int MAX_MASTERS = 4;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    // len encodes (beats - 1)
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef logic [$clog2(MAX_MASTERS)-1:0] master_id_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [2:0]         size;
        logic [CBUS_AW-1:0] addr;
        logic [3:0]         strobe;
        logic [CBUS_DW-1:0] data;
        logic [3:0]         len;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CBUS_DW-1:0] data;
    } cbus_resp_t;

    // First valid index scanning ptr, ptr+1, ... modulo n.
    function automatic master_id_t rr_pick(input logic [MAX_MASTERS-1:0] valid,
                                           input master_id_t ptr, input int n);
        master_id_t win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx]) begin
                win   = master_id_t'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_priority_encoder.sv
// Masked round-robin picker: lowest valid index at or above ptr_i, otherwise
// the lowest valid index overall (wrap-around).
module rr_priority_encoder #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] grant_o,
    output logic                 any_o
);
    localparam int W = $clog2(N);

    logic [N-1:0] mask;
    logic [N-1:0] masked;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr_i));
        end
    end

    assign masked = valid_i & mask;
    assign any_o  = |valid_i;

    // Descending scans so the lowest matching index is written last.
    always_comb begin
        grant_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[i]) grant_o = W'(i);
        end
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) grant_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one cbus memory port among NUM_MASTERS requesters; a grant lasts for a
// whole burst and ends on the response beat carrying last.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  cbus_req_t  [NUM_MASTERS-1:0]   mreq,
    output cbus_resp_t [NUM_MASTERS-1:0]   mresp,
    output cbus_req_t                      oreq,
    input  cbus_resp_t                     oresp,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id
);
    localparam int IDW = $clog2(NUM_MASTERS);

    arb_state_e       state_q;
    logic [IDW-1:0]   grant_id_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [IDW-1:0]   ptr_sel;
    logic [IDW-1:0]   pick;
    logic             any_valid;
    logic             burst_end;
    logic [NUM_MASTERS-1:0] vld;
    logic [MAX_MASTERS-1:0] vld_ext;

    always_comb begin
        vld     = '0;
        vld_ext = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            vld[i]     = mreq[i].valid;
            vld_ext[i] = mreq[i].valid;
        end
    end

    // Fixed priority is round-robin pinned to pointer 0.
    assign ptr_sel = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

    rr_priority_encoder #(.N(NUM_MASTERS)) u_pick (
        .valid_i (vld),
        .ptr_i   (ptr_sel),
        .grant_o (pick),
        .any_o   (any_valid)
    );

    assign burst_end = oresp.ready & oresp.last;
    assign rr_ptr_d  = (grant_id_q == IDW'(NUM_MASTERS - 1)) ? '0 : grant_id_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_valid) begin
                        grant_id_q <= pick;
                        state_q    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A request seen on the ending beat waits for the next IDLE cycle.
                    if (burst_end) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ARB_BUSY);
    assign grant_id = grant_id_q;

    // Request path depends only on registered state and mreq, never on oresp.
    always_comb begin
        oreq = '0;
        if (state_q == ARB_BUSY) oreq = mreq[grant_id_q];
    end

    always_comb begin
        for (int j = 0; j < NUM_MASTERS; j++) begin
            mresp[j]      = '0;
            mresp[j].data = oresp.data;
            if (state_q == ARB_BUSY && grant_id_q == IDW'(j)) begin
                mresp[j].ready = oresp.ready;
                mresp[j].last  = oresp.last;
            end
        end
    end

    // Granted master must hold valid until it sees last.
    a_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q == ARB_BUSY) |-> mreq[grant_id_q].valid);

    a_pick: assert property (@(posedge clk) disable iff (reset)
        (state_q == ARB_IDLE && any_valid) |->
            (master_id_t'(pick) == rr_pick(vld_ext, master_id_t'(ptr_sel), NUM_MASTERS)));

endmodule

// File: tb/tb_cbus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with random masters and a
// random-stall bridge, comparing every cycle against a burst-level model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N      = 3;
    localparam int ND     = 2;
    localparam int CYCLES = 2000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  [N-1:0] mreq  [ND];
    cbus_resp_t [N-1:0] mresp [ND];
    cbus_req_t          oreq  [ND];
    cbus_resp_t         oresp [ND];
    logic               busy  [ND];
    logic [1:0]         gid   [ND];

    cbus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset), .mreq(mreq[0]), .mresp(mresp[0]),
        .oreq(oreq[0]), .oresp(oresp[0]), .busy(busy[0]), .grant_id(gid[0]));

    cbus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(reset), .mreq(mreq[1]), .mresp(mresp[1]),
        .oreq(oreq[1]), .oresp(oresp[1]), .busy(busy[1]), .grant_id(gid[1]));

    int checks = 0;
    int errors = 0;

    // Burst-level model: who owns the bus, whose turn is next, beats served.
    int owner [ND];
    int ptr   [ND];
    int lgid  [ND];
    int bc    [ND];
    logic        m_act  [ND][N];
    logic        m_wr   [ND][N];
    logic [31:0] m_addr [ND][N];
    logic [3:0]  m_len  [ND][N];
    int          m_beat [ND][N];
    logic        obs_rdy  [ND][N];
    logic        obs_last [ND][N];
    logic        rst_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wdata(input logic [31:0] a, input int b);
        return a + 32'(b);
    endfunction

    function automatic logic [31:0] rdata(input logic [31:0] a, input int b);
        return ~a + 32'(b * 3);
    endfunction

    function automatic int winner(input int d);
        int base;
        base = (d == 0) ? ptr[d] : 0;
        for (int k = 0; k < N; k++) begin
            if (m_act[d][(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] rand_len();
        case ($urandom_range(4))
            0:       return MLEN1;
            1:       return MLEN2;
            2:       return MLEN4;
            3:       return MLEN8;
            default: return MLEN16;
        endcase
    endfunction

    task automatic model_update();
        int w;
        for (int d = 0; d < ND; d++) begin
            if (reset) begin
                owner[d] = -1; ptr[d] = 0; lgid[d] = 0; bc[d] = 0;
                for (int j = 0; j < N; j++) m_act[d][j] = 1'b0;
            end else begin
                if (owner[d] < 0) begin
                    w = winner(d);
                    if (w >= 0) begin owner[d] = w; lgid[d] = w; bc[d] = 0; end
                end else if (oresp[d].ready && oresp[d].last) begin
                    ptr[d] = (owner[d] + 1) % N; owner[d] = -1; bc[d] = 0;
                end else if (oresp[d].ready) begin
                    bc[d]++;
                end
                for (int j = 0; j < N; j++) begin
                    if (obs_rdy[d][j]) begin
                        m_beat[d][j]++;
                        if (obs_last[d][j]) m_act[d][j] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive(input int cyc);
        int o;
        reset = (cyc < 2);
        if (!rst_done && cyc > 600 && owner[0] >= 0 && bc[0] == 7) begin
            reset = 1'b1; rst_done = 1'b1;
        end
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < N; j++) begin
                if (!m_act[d][j] && !reset) begin
                    if (cyc == 2 && j == 1) begin
                        m_act[d][j] = 1'b1; m_wr[d][j] = 1'b0;
                        m_addr[d][j] = 32'h8000_0040; m_len[d][j] = MLEN16; m_beat[d][j] = 0;
                    end else if (cyc >= 40 && $urandom_range(3) == 0) begin
                        m_act[d][j] = 1'b1; m_wr[d][j] = 1'($urandom_range(1));
                        m_addr[d][j] = $urandom & 32'hFFFF_FFC0; m_len[d][j] = rand_len();
                        m_beat[d][j] = 0;
                    end
                end
                mreq[d][j] = '0;
                if (m_act[d][j]) begin
                    mreq[d][j].valid    = 1'b1;
                    mreq[d][j].is_write = m_wr[d][j];
                    mreq[d][j].size     = MSIZE4;
                    mreq[d][j].addr     = m_addr[d][j];
                    mreq[d][j].strobe   = 4'hF;
                    mreq[d][j].len      = m_len[d][j];
                    mreq[d][j].data     = m_wr[d][j] ? wdata(m_addr[d][j], m_beat[d][j]) : 32'h0;
                end
            end
            o = owner[d];
            oresp[d] = '0;
            oresp[d].data = 32'hDEAD_0000 + 32'(cyc);
            if (o >= 0 && !reset && m_act[d][o] && (cyc < 40 || $urandom_range(3) != 0)) begin
                oresp[d].ready = 1'b1;
                oresp[d].last  = (bc[d] == int'(m_len[d][o]));
                oresp[d].data  = rdata(m_addr[d][o], bc[d]);
            end
        end
    endtask

    task automatic check_outputs();
        int   o;
        logic ev;
        string p;
        for (int d = 0; d < ND; d++) begin
            p = (d == 0) ? "rr" : "fp";
            o = owner[d];
            ev = (o >= 0) && m_act[d][o];
            chk({p, ".busy"}, 64'(busy[d]), 64'(o >= 0));
            chk({p, ".grant_id"}, 64'(gid[d]), 64'(lgid[d]));
            chk({p, ".oreq.valid"}, 64'(oreq[d].valid), 64'(ev));
            if (ev) begin
                chk({p, ".oreq.addr"}, 64'(oreq[d].addr), 64'(m_addr[d][o]));
                chk({p, ".oreq.is_write"}, 64'(oreq[d].is_write), 64'(m_wr[d][o]));
                chk({p, ".oreq.len"}, 64'(oreq[d].len), 64'(m_len[d][o]));
                if (m_wr[d][o]) chk({p, ".oreq.data"}, 64'(oreq[d].data), 64'(wdata(m_addr[d][o], bc[d])));
            end
            for (int j = 0; j < N; j++) begin
                chk($sformatf("%s.mresp%0d.ready", p, j), 64'(mresp[d][j].ready),
                    64'(o == j && oresp[d].ready));
                chk($sformatf("%s.mresp%0d.last", p, j), 64'(mresp[d][j].last),
                    64'(o == j && oresp[d].ready && oresp[d].last));
                obs_rdy[d][j]  = mresp[d][j].ready;
                obs_last[d][j] = mresp[d][j].last;
                if (mresp[d][j].ready && m_act[d][j]) begin
                    chk($sformatf("%s.mresp%0d.data", p, j), 64'(mresp[d][j].data),
                        64'(rdata(m_addr[d][j], m_beat[d][j])));
                    chk($sformatf("%s.mresp%0d.last_at_len", p, j), 64'(mresp[d][j].last),
                        64'(m_beat[d][j] == int'(m_len[d][j])));
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        rst_done = 1'b0;
        for (int d = 0; d < ND; d++) begin
            owner[d] = -1; ptr[d] = 0; lgid[d] = 0; bc[d] = 0;
            oresp[d] = '0;
            for (int j = 0; j < N; j++) begin
                mreq[d][j] = '0; m_act[d][j] = 1'b0; m_wr[d][j] = 1'b0;
                m_addr[d][j] = '0; m_len[d][j] = '0; m_beat[d][j] = 0;
                obs_rdy[d][j] = 1'b0; obs_last[d][j] = 1'b0;
            end
        end
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            drive(cyc);
            #1;
            check_outputs();
        end
        chk("mid_burst_reset_hit", 64'(rst_done), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single cache-bus (cbus) memory port between NUM_MASTERS cache-side requesters (index 0 = ICache, 1 = DCache, 2 = uncached/MMIO path when present).
- Grants one master at a time for the whole burst, from the first beat until the response with last=1. Forwards that master's cbus request downstream and routes the response back only to it.
- Sits between the cache controllers and the AXI/cbus bridge. It is the only writer of the downstream cbus request.

Parameters:
- NUM_MASTERS, 2: number of requesting masters; legal range 2..4.
- ROUND_ROBIN, 1: 1 = round-robin grant; 0 = fixed priority, where the lowest index wins.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mreq  in  NUM_MASTERS x cbus_req_t  per-master requests (valid, is_write, size, addr, strobe, data, len).
- mresp  out  NUM_MASTERS x cbus_resp_t  per-master responses (ready, last, data).
- oreq  out  cbus_req_t  request to the memory bridge.
- oresp  in  cbus_resp_t  response from the memory bridge.
- busy  out  1  a burst is in progress (state == BUSY).
- grant_id  out  clog2(NUM_MASTERS)  index of the current or last granted master.

Behaviour:
- State machine with two states: IDLE and BUSY. Registers: state, grant_id, rr_ptr (next master with highest priority).
- Reset (synchronous, reset=1 sampled at posedge):
  - state=IDLE, grant_id=0, rr_ptr=0.
  - During and after reset, oreq.valid=0 and every mresp[i].ready=0 and .last=0.
- IDLE arbitration:
  - If any mreq[i].valid, pick the winner and register it into grant_id, then state<=BUSY.
  - Round-robin: the winner is the first valid master scanning rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - Fixed priority: the winner is the lowest valid index.
  - The grant takes effect in the next cycle. Grant latency is 1 cycle from valid, and oreq.valid=0 while IDLE.
- BUSY:
  - oreq = mreq[grant_id], driven combinationally (no register stage on the request path).
  - mresp[grant_id] = oresp. Every other mresp[j] gets ready=0, last=0, data=oresp.data (data is don't-care when ready=0).
- Burst end: in BUSY, when oresp.ready & oresp.last:
  - state<=IDLE.
  - rr_ptr<=grant_id+1, wrapping to 0 at NUM_MASTERS.
  - Always one idle bubble cycle between bursts, so back-to-back bursts from different masters are 1 cycle apart.
- Hold rule: a granted master keeps valid and all request fields stable until it sees last.
  - If the granted master deasserts valid in BUSY, oreq.valid follows it (goes 0) and state stays BUSY. No regrant happens until last. This is a protocol violation and is flagged by an assertion.
- Simultaneous requests: requesters that lose stay pending with no timeout. Round-robin guarantees each valid requester a grant within NUM_MASTERS bursts.
- A request arriving in the cycle a burst ends is not granted that cycle. It is arbitrated in the following IDLE cycle.
- Reset mid-burst: state returns to IDLE immediately and oreq.valid drops next cycle. The bridge is reset on the same signal, so no burst completion is owed.
- Writes and reads are treated identically. The arbiter never inspects len or counts beats; burst end is determined by last only.
- No combinational path from oresp to oreq.

Decomposition:
- Shared package (existing common package): cbus_req_t, cbus_resp_t, MLEN*/MSIZE* constants (already present).
- Add to the package: function rr_pick(valid, ptr) returning the winner index, plus a localparam type for master_id_t.
- One natural sub-module: rr_priority_encoder, a combinational masked round-robin picker parameterised on NUM_MASTERS. Everything else stays in cbus_arbiter.

Test Plan:
- Single master: reset then mreq[1] DCache read, len=MLEN16, addr 0x8000_0040.
  - Required: oreq.valid=1 from cycle 2 with that addr; 16 ready beats reach mresp[1] only; mresp[0].ready=0 throughout; IDLE the cycle after last.
- Contention (ROUND_ROBIN=1): both masters valid in the same cycle with rr_ptr=0.
  - Required: master 0 burst completes first, bubble, then master 1; grant_id sequence 0 then 1; rr_ptr=0 after both.
- Fixed priority (ROUND_ROBIN=0): master 1 bursts repeatedly while master 0 requests once.
  - Required: master 0 wins at the first IDLE after its valid.
- Write burst: master 1 writes len=MLEN16, strobe=4'hF, data stepping 0..15.
  - Required: oreq.is_write=1 and the data sequence appears unchanged on oreq; ends on oresp.last.
- Reset mid-burst: assert reset at beat 7 of 16.
  - Required: busy=0 and oreq.valid=0 the next cycle; all mresp ready=0; a fresh request afterwards is granted normally.
- Late arrival: master 0 raises valid in the same cycle master 1's last arrives.
  - Required: master 0 is granted one cycle later, not in the same cycle.
